vector_op_dispatch: RTL

Initiator/sequencer for the tiled vector arithmetic units (vector_add, vector_subtract, and similar), driving their `start` input and consuming their `result`/`valid` outputs. Accepts an operand pair over a valid/ready handshake, registers it, pulses `start`, waits for the unit's `valid`, captures the result vector and presents it downstream on a valid/ready handshake. A bounded wait counter flags units that never respond, so the backprop datapath cannot hang.

---
 rtl/vector_op_dispatch.sv | 126 ++++++++++++
 1 files changed

// File: rtl/vector_op_dispatch.sv
// vector_op_dispatch
//   Sequencer in front of a tiled vector arithmetic unit. It takes one operand
//   pair per transaction, registers it and pulses op_start. It then waits for
//   the unit's op_valid and presents the captured result downstream.
//   A bounded wait counter turns a unit that never answers into a zero result
//   flagged by out_timeout. This keeps the consumer from hanging.
//
// Ports
//   clk, rst              clock / async active-high reset
//   in_valid, in_ready    operand handshake (a, b packed by cell)
//   op_start, op_a, op_b  start pulse and registered operands to the unit
//   op_result, op_valid   unit response
//   out_valid, out_ready  result handshake (result, out_timeout)
//   busy                  transaction in flight (state != IDLE)
module vector_op_dispatch #(
    parameter int VECTOR_LEN        = 5,
    parameter int A_CELL_WIDTH      = 8,
    parameter int B_CELL_WIDTH      = 8,
    parameter int RESULT_CELL_WIDTH = 8,
    parameter int TIMEOUT           = 64,
    parameter int TIMEOUT_WIDTH     = 7
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    input  logic [VECTOR_LEN*A_CELL_WIDTH-1:0]      a,
    input  logic [VECTOR_LEN*B_CELL_WIDTH-1:0]      b,
    output logic                                   op_start,
    output logic [VECTOR_LEN*A_CELL_WIDTH-1:0]      op_a,
    output logic [VECTOR_LEN*B_CELL_WIDTH-1:0]      op_b,
    input  logic [VECTOR_LEN*RESULT_CELL_WIDTH-1:0] op_result,
    input  logic                                   op_valid,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic [VECTOR_LEN*RESULT_CELL_WIDTH-1:0] result,
    output logic                                   out_timeout,
    output logic                                   busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    localparam logic [TIMEOUT_WIDTH-1:0] CNT_LAST = TIMEOUT_WIDTH'(TIMEOUT - 1);

    state_t                                              r_state;
    state_t                                              w_next;
    logic [TIMEOUT_WIDTH-1:0]                            r_cnt;
    logic [VECTOR_LEN*A_CELL_WIDTH-1:0]                  r_op_a;
    logic [VECTOR_LEN*B_CELL_WIDTH-1:0]                  r_op_b;
    logic [VECTOR_LEN-1:0][RESULT_CELL_WIDTH-1:0]        r_res;
    logic                                                r_timeout;

    logic w_accept;
    logic w_capture;
    logic w_expire;

    assign w_accept  = (r_state == S_IDLE) && in_valid;
    // A response in the last WAIT cycle beats the timeout.
    assign w_capture = (r_state == S_WAIT) && op_valid;
    assign w_expire  = (r_state == S_WAIT) && !op_valid && (r_cnt == CNT_LAST);

    // ---------------- state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // ---------------- next-state ----------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (in_valid) w_next = S_ISSUE;
            S_ISSUE: w_next = S_WAIT;
            S_WAIT:  if (w_capture || w_expire) w_next = S_HOLD;
            S_HOLD:  if (out_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // ---------------- operands and wait counter ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op_a <= '0;
            r_op_b <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_accept) begin
                r_op_a <= a;
                r_op_b <= b;
            end
            if (r_state == S_ISSUE)     r_cnt <= '0;
            else if (r_state == S_WAIT) r_cnt <= r_cnt + 1'b1;
        end
    end

    // ---------------- result capture, one register per cell ----------------
    for (genvar gi = 0; gi < VECTOR_LEN; gi++) begin : g_cell
        always_ff @(posedge clk or posedge rst) begin
            if (rst)            r_res[gi] <= '0;
            else if (w_capture) r_res[gi] <= op_result[gi*RESULT_CELL_WIDTH +: RESULT_CELL_WIDTH];
            else if (w_expire)  r_res[gi] <= '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)            r_timeout <= 1'b0;
        else if (w_capture) r_timeout <= 1'b0;
        else if (w_expire)  r_timeout <= 1'b1;
    end

    // ---------------- outputs: pure state decodes / registers ----------------
    assign in_ready    = (r_state == S_IDLE);
    assign op_start    = (r_state == S_ISSUE);
    assign out_valid   = (r_state == S_HOLD);
    assign busy        = (r_state != S_IDLE);
    assign op_a        = r_op_a;
    assign op_b        = r_op_b;
    assign result      = r_res;
    assign out_timeout = r_timeout;

endmodule
